// File: rtl/serial_addsub_nbit.sv
// Bit-serial N-bit adder/subtractor: one full adder and a carry flop walk the
// operands LSB-first through two right-shift registers, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; last result/cout/overflow held
// RUN   | one operand bit processed per edge
// DONE  | one-cycle done pulse, outputs valid
module serial_addsub_nbit #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    add_q, add_d;
  logic            carry_q, carry_d;
  logic            cmsb_q, cmsb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fa_sum;

  assign fa_sum = {1'b0, acc_q[0]} + {1'b0, add_q[0]} + {1'b0, carry_q};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      add_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      add_q   <= add_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    add_d   = add_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: the +1 enters through the initial carry.
          acc_d   = a;
          add_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {fa_sum[0], acc_q[N-1:1]};
        add_d   = {1'b0, add_q[N-1:1]};
        carry_d = fa_sum[1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          cmsb_d  = carry_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = acc_q;
  assign cout     = carry_q;
  assign overflow = cmsb_q ^ carry_q;

endmodule

// File: doc/serial_addsub_nbit.md
SERIAL_ADDSUB_NBIT -- requirements
Module: serial_addsub_nbit

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the operand width in bits, legal range 2..32.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The module SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-005 The module SHALL have port sub, input, 1 bit: mode select, 0 = a+b, 1 = a-b, sampled with start.
REQ-006 The module SHALL have port a, input, N bits: first operand, unsigned or two's complement, sampled with start.
REQ-007 The module SHALL have port b, input, N bits: second operand, sampled with start.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an operation is in progress (state RUN).
REQ-009 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking result, cout and overflow as valid.
REQ-010 The module SHALL have port result, output, N bits: sum or difference, held until the next accepted start.
REQ-011 The module SHALL have port cout, output, 1 bit: final carry out; for sub, 1 = no borrow.
REQ-012 The module SHALL have port overflow, output, 1 bit: two's-complement overflow flag.

Function
REQ-013 The datapath SHALL be bit-serial: one 1-bit full adder, one carry flip-flop, and two N-bit right-shift registers (accumulator A and addend B).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 On a rising edge in IDLE with start=1, the block SHALL load A<=a, load B<=(sub ? ~b : b), set carry<=sub, set the bit counter to 0 and enter RUN.
REQ-016 On each rising edge in RUN, the block SHALL compute {c,s}=A[0]+B[0]+carry, shift A right with s entering A[N-1], shift B right with 0 entering B[N-1], set carry<=c and increment the counter.
REQ-017 On the RUN edge that processes bit N-1, the block SHALL store the carry-in of that bit (c_msb) and transition to DONE.
REQ-018 Latency: if start is sampled at edge E0, RUN SHALL occupy edges E1..EN, and done SHALL be high in the cycle following EN, for exactly one cycle.
REQ-019 In DONE, result SHALL equal A (a+b or a-b mod 2^N), cout SHALL equal carry, and overflow SHALL equal c_msb XOR carry.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-021 result, cout and overflow SHALL hold their values through IDLE until the next accepted start loads new operands.
REQ-022 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-023 Changes on a, b or sub after the start edge SHALL have no effect on the operation in progress.
REQ-024 Back-to-back operation: start held high continuously SHALL launch a new operation every N+2 cycles.
REQ-025 The bit counter SHALL be ceil(log2(N))+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-026 While clear=1, the block SHALL immediately, without waiting for a clock edge, force: state=IDLE, A=0, B=0, carry=0, c_msb=0, counter=0, busy=0, done=0, result=0, cout=0, overflow=0.
REQ-027 An assertion of clear during RUN SHALL abort the operation: no done pulse is produced and the partial result is discarded.
REQ-028 After clear deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (N=4)
REQ-029 The bench SHALL apply a=0111, b=0110, sub=0 -> after 4 RUN cycles, done pulses once with result=1101, cout=0, overflow=1.
REQ-030 The bench SHALL apply a=0110, b=0111, sub=1 -> result=1111, cout=0 (borrow), overflow=0.
REQ-031 The bench SHALL apply a=1111, b=0001, sub=0 -> result=0000, cout=1, overflow=0; then a=1000, b=0001, sub=1 -> result=0111, cout=1, overflow=1.
REQ-032 The bench SHALL start an operation and pulse start again during RUN with different operands -> the first result is unaffected, exactly one done pulse occurs, and busy stays high for exactly 4 cycles.
REQ-033 The bench SHALL assert clear after 2 RUN cycles, asynchronously between edges -> busy, done and result are 0 immediately; a subsequent 0011+0001 yields result=0100 after the nominal latency.
REQ-034 The bench SHALL rebuild with N=8, hold start=1, and run 0x7F+0x01 -> result=0x80 with overflow=1, with done pulses spaced every 10 cycles.
